// File: rtl/enemy_walker_if.sv
// Bundle between the enemy walker and the playfield: obstacle/flame maps in, sprite position and state out.
interface enemy_walker_if #(
  parameter int unsigned GRID_W = 12,
  parameter int unsigned GRID_H = 12
);
  localparam int unsigned CELLS = GRID_W * GRID_H;
  localparam int unsigned COL_W = $clog2(GRID_W);
  localparam int unsigned ROW_W = $clog2(GRID_H);

  logic             Enable;
  logic [CELLS-1:0] Block_Map;
  logic [CELLS-1:0] Flame_Map;
  logic [9:0]       Enemy_X;
  logic [9:0]       Enemy_Y;
  logic [COL_W-1:0] Enemy_Col;
  logic [ROW_W-1:0] Enemy_Row;
  logic [1:0]       Enemy_Dir;
  logic             Moving;
  logic             Alive;
  logic [7:0]       Step_Count;

  modport master (
    input  Enable, Block_Map, Flame_Map,
    output Enemy_X, Enemy_Y, Enemy_Col, Enemy_Row, Enemy_Dir, Moving, Alive, Step_Count
  );

  modport slave (
    output Enable, Block_Map, Flame_Map,
    input  Enemy_X, Enemy_Y, Enemy_Col, Enemy_Row, Enemy_Dir, Moving, Alive, Step_Count
  );
endinterface

// File: rtl/enemy_walker.sv
// Grid-walking enemy: picks a direction at each tile centre from an LFSR and the
// obstacle map, glides to the neighbour tile in fixed pixel steps, dies in flame.
module enemy_walker #(
  parameter int unsigned GRID_W    = 12,
  parameter int unsigned GRID_H    = 12,
  parameter int unsigned TILE      = 40,
  parameter int unsigned STEP      = 1,
  parameter int unsigned START_COL = 1,
  parameter int unsigned START_ROW = 1,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input logic            Frame_Clk,
  input logic            Reset_N,
  enemy_walker_if.master bus
);
  localparam int unsigned CELLS     = GRID_W * GRID_H;
  localparam int unsigned IDX_W     = $clog2(CELLS);
  localparam int unsigned COL_W     = $clog2(GRID_W);
  localparam int unsigned ROW_W     = $clog2(GRID_H);
  localparam int unsigned LAST_STEP = TILE / STEP - 1;

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DEAD} state_t;

  function automatic logic [IDX_W-1:0] tile_idx(input logic [ROW_W-1:0] r,
                                                input logic [COL_W-1:0] c);
    return IDX_W'(32'(r) * GRID_W + 32'(c));
  endfunction

  function automatic logic [9:0] centre(input int unsigned t);
    return 10'(t * TILE + TILE / 2);
  endfunction

  state_t           state_q, state_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic [COL_W-1:0] col_q, col_d, tcol_q, tcol_d;
  logic [ROW_W-1:0] row_q, row_d, trow_q, trow_d;
  logic [1:0]       dir_q, dir_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [15:0]      lfsr_q, lfsr_d, lfsr_nx;
  logic             moving_q, alive_q;

  logic [COL_W-1:0] nb_col [4];
  logic [ROW_W-1:0] nb_row [4];
  logic [3:0]       open;
  logic [1:0]       pick, cand;
  logic             found;
  logic             flame_hit;

  // Neighbour tiles, which of them are enterable, and the direction choice
  always_comb begin
    nb_col[0] = col_q;                nb_row[0] = row_q - ROW_W'(1);
    nb_col[1] = col_q + COL_W'(1);    nb_row[1] = row_q;
    nb_col[2] = col_q;                nb_row[2] = row_q + ROW_W'(1);
    nb_col[3] = col_q - COL_W'(1);    nb_row[3] = row_q;

    open[0] = (row_q != '0) && !bus.Block_Map[tile_idx(nb_row[0], nb_col[0])];
    open[1] = (32'(col_q) < GRID_W - 1) && !bus.Block_Map[tile_idx(nb_row[1], nb_col[1])];
    open[2] = (32'(row_q) < GRID_H - 1) && !bus.Block_Map[tile_idx(nb_row[2], nb_col[2])];
    open[3] = (col_q != '0) && !bus.Block_Map[tile_idx(nb_row[3], nb_col[3])];

    pick  = dir_q;
    found = 1'b0;
    cand  = 2'd0;
    if (lfsr_q[3:2] != 2'b00 && open[dir_q]) begin
      found = 1'b1;
    end else begin
      // Scan downward so the lowest offset from d0 wins
      for (int k = 3; k >= 0; k--) begin
        cand = lfsr_q[1:0] + 2'(k);
        if (open[cand]) begin
          found = 1'b1;
          pick  = cand;
        end
      end
    end

    flame_hit = bus.Flame_Map[tile_idx(row_q, col_q)] ||
                ((state_q == S_MOVE) && bus.Flame_Map[tile_idx(trow_q, tcol_q)]);

    lfsr_nx = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  // Next state: death outranks the enable freeze, which outranks walking
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    col_d   = col_q;
    row_d   = row_q;
    tcol_d  = tcol_q;
    trow_d  = trow_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;

    if (state_q != S_DEAD) begin
      if (flame_hit) begin
        state_d = S_DEAD;
      end else if (bus.Enable) begin
        lfsr_d = lfsr_nx;
        if (state_q == S_IDLE) begin
          if (found) begin
            dir_d   = pick;
            tcol_d  = nb_col[pick];
            trow_d  = nb_row[pick];
            state_d = S_MOVE;
          end
        end else if (cnt_q == 8'(LAST_STEP)) begin
          x_d     = centre(32'(tcol_q));
          y_d     = centre(32'(trow_q));
          col_d   = tcol_q;
          row_d   = trow_q;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          unique case (dir_q)
            2'd0:    y_d = y_q - 10'(STEP);
            2'd1:    x_d = x_q + 10'(STEP);
            2'd2:    y_d = y_q + 10'(STEP);
            default: x_d = x_q - 10'(STEP);
          endcase
        end
      end
    end
  end

  always_ff @(posedge Frame_Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q  <= S_IDLE;
      x_q      <= centre(START_COL);
      y_q      <= centre(START_ROW);
      col_q    <= COL_W'(START_COL);
      row_q    <= ROW_W'(START_ROW);
      tcol_q   <= COL_W'(START_COL);
      trow_q   <= ROW_W'(START_ROW);
      dir_q    <= 2'd0;
      cnt_q    <= 8'd0;
      lfsr_q   <= SEED;
      moving_q <= 1'b0;
      alive_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      col_q    <= col_d;
      row_q    <= row_d;
      tcol_q   <= tcol_d;
      trow_q   <= trow_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      moving_q <= (state_d == S_MOVE);
      alive_q  <= (state_d != S_DEAD);
    end
  end

  assign bus.Enemy_X    = x_q;
  assign bus.Enemy_Y    = y_q;
  assign bus.Enemy_Col  = col_q;
  assign bus.Enemy_Row  = row_q;
  assign bus.Enemy_Dir  = dir_q;
  assign bus.Moving     = moving_q;
  assign bus.Alive      = alive_q;
  assign bus.Step_Count = cnt_q;
endmodule

// File: doc/enemy_walker.md
# enemy_walker

Autonomous grid-walking enemy for the Bomberman playfield, driven once per frame by `Frame_Clk`. It chooses a direction at each tile centre from a pseudo-random LFSR and a combined obstacle map, then glides tile-to-tile in fixed pixel steps. It dies when a flame covers its tile. It sits beside the player avatar logic and feeds its pixel position and state to the sprite/draw stage and to collision and scoring logic.

## Interface
- `GRID_W`, 12: playfield columns.
- `GRID_H`, 12: playfield rows.
- `TILE`, 40: tile size in pixels. Must be divisible by `STEP`.
- `STEP`, 1: pixels moved per frame.
- `START_COL`, 1: spawn column.
- `START_ROW`, 1: spawn row.
- `SEED`, 16'hACE1: LFSR reset value. Must be nonzero.

- `Frame_Clk`  in  1: frame clock. All state updates on its rising edge.
- `Reset_N`  in  1: asynchronous, active-low reset.
- `Enable`  in  1: when low, movement, the LFSR and the step counter freeze.
- `Block_Map`  in  GRID_W*GRID_H: 1 = impassable tile (wall, tree, treasure or bomb, ORed upstream). Bit index = row*GRID_W+col.
- `Flame_Map`  in  GRID_W*GRID_H: 1 = tile currently burning.
- `Enemy_X`, `Enemy_Y`  out  10: sprite centre in pixels.
- `Enemy_Col`, `Enemy_Row`  out  $clog2(GRID_W), $clog2(GRID_H): current tile.
- `Enemy_Dir`  out  2: last chosen direction. 0 = up, 1 = right, 2 = down, 3 = left.
- `Moving`  out  1: high in the MOVE state.
- `Alive`  out  1: low once killed.
- `Step_Count`  out  8: frames elapsed in the current move.

## Operation
- **States**
  - IDLE: centred on a tile.
  - MOVE: travelling to the neighbouring tile.
  - DEAD: terminal until reset.
- **Reset values**
  - State = IDLE.
  - `Enemy_Col` = START_COL, `Enemy_Row` = START_ROW.
  - `Enemy_X` = START_COL*TILE + TILE/2, `Enemy_Y` = START_ROW*TILE + TILE/2.
  - `Enemy_Dir` = 0, `Moving` = 0, `Alive` = 1, `Step_Count` = 0.
  - LFSR = SEED.
- **Open[d]**: the neighbour tile in direction d is inside the grid and its `Block_Map` bit is 0.
  - Any out-of-grid neighbour is blocked.
  - Index arithmetic never wraps to another row.
- **LFSR**: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. Advances every frame while `Enable`=1 and state != DEAD.
- **IDLE decision** (one frame, uses the current LFSR value):
  - If LFSR[3:2] != 0 and Open[Enemy_Dir]: keep `Enemy_Dir`.
  - Otherwise, with d0 = LFSR[1:0], pick the first open direction among d0, d0+1, d0+2, d0+3 (mod 4).
  - If no direction is open: remain in IDLE and leave `Enemy_Dir` unchanged.
  - If a direction is chosen: latch it in `Enemy_Dir`, latch the target tile, and enter MOVE.
- **MOVE**
  - Each frame: `Enemy_X`/`Enemy_Y` change by ±STEP along `Enemy_Dir`, and `Step_Count` increments.
  - When `Step_Count` reaches TILE/STEP−1, on that same edge:
    - the position equals the target centre exactly;
    - `Enemy_Col`/`Enemy_Row` take the target tile;
    - `Step_Count` returns to 0;
    - state returns to IDLE.
  - `Block_Map` changes during MOVE (e.g. a bomb dropped on the target) do not abort the move.
- **Death check**: every frame, including when `Enable`=0. If `Flame_Map` is set at the current tile, or at the target tile while in MOVE:
  - state goes to DEAD, `Alive` = 0, `Moving` = 0;
  - position, `Enemy_Dir` and `Step_Count` freeze.
- **Priority**: Reset_N > death > Enable > decision/move.

## Timing
- One tile costs TILE/STEP MOVE frames plus one IDLE decision frame. With defaults, that is 41 frames per tile.
- `Moving` rises on the edge that leaves IDLE. It falls on the arrival edge.
- Flame-to-`Alive` latency: 1 frame. `Alive` is registered.
- Reset asserted mid-move: all outputs return to their reset values asynchronously. Movement restarts from spawn after deassertion.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- **Reset**: `Reset_N`=0 then 1, defaults → `Enemy_X`=60, `Enemy_Y`=60, `Col`=1, `Row`=1, `Alive`=1, `Moving`=0.
- **Forced corridor**: all neighbours of (1,1) blocked except right → after 41 frames, `Col`=2, `Enemy_X`=100, `Enemy_Dir`=1, with `Moving` high for exactly 40 frames.
- **Boxed in**: all four neighbours blocked for 100 frames → `Moving` stays 0 and the position stays at 60,60. Then unblock down → `Enemy_Dir`=2 on the next decision frame.
- **Grid edge**: spawn at (0,0) with only up and left unblocked in `Block_Map` → never moves (out-of-grid treated as blocked).
- **Death**: set `Flame_Map` bit 13 (tile (1,1)) after 20 MOVE frames heading right → `Alive`=0 next frame and `Enemy_X` frozen at 80. `Enable` toggling has no effect afterwards.
- **Freeze and reset**: `Enable`=0 at `Step_Count`=10 for 5 frames → position and count hold, then resume. `Reset_N` pulse at `Step_Count`=25 → immediate return to 60,60.
